weight_sched: RTL and testbench

WEIGHT_SCHED -- requirements
Module: weight_sched

---
 rtl/weight_pkg.sv | 18 +
 rtl/weight_sched_if.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/weight_sched.sv | 104 ++++++++++
 tb/tb_weight_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_pkg.sv
// Shared state encoding and width helper for the weight scheduler slice.
package weight_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

  // Ceiling log2, floored at 1 so single-entry configurations keep a 1-bit field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/weight_sched_if.sv
// Bus between the weight scheduler and its loader and read requesters.
interface weight_sched_if #(
  parameter int NUM_SYNAPSES = 16,
  parameter int WIDTH_P      = 8,
  parameter int NUM_REQ      = 2
);
  localparam int AW = weight_pkg::clog2(NUM_SYNAPSES);
  localparam int RW = weight_pkg::clog2(NUM_REQ);

  logic                  start_i;
  logic [WIDTH_P-1:0]    rand_i;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*AW-1:0] addr_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic                  rvalid_o;
  logic [WIDTH_P-1:0]    rdata_o;
  logic [RW-1:0]         rid_o;
  logic                  busy_o;
  logic                  ready_o;
  logic                  done_o;

  modport master (
    output start_i, rand_i, req_i, addr_i,
    input  gnt_o, rvalid_o, rdata_o, rid_o, busy_o, ready_o, done_o
  );

  modport slave (
    input  start_i, rand_i, req_i, addr_i,
    output gnt_o, rvalid_o, rdata_o, rid_o, busy_o, ready_o, done_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the owner keeps the priority pointer.
module rr_arbiter import weight_pkg::*; #(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic                en,
  input  logic [clog2(N)-1:0] ptr,
  output logic [N-1:0]        gnt
);

  localparam int unsigned NU = unsigned'(N);

  logic found;

  // Pick the requester with the smallest rotational distance from ptr.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned d = 0; d < NU; d++) begin
      for (int unsigned k = 0; k < NU; k++) begin
        if (en && !found && req[k] && (((k + NU - 32'(ptr)) % NU) == d)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/weight_sched.sv
// Weight bank loaded from a random source, then served to round-robin readers.
module weight_sched import weight_pkg::*; #(
  parameter int NUM_SYNAPSES = 16,
  parameter int WIDTH_P      = 8,
  parameter int NUM_REQ      = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  weight_sched_if.slave bus
);

  localparam int AW = clog2(NUM_SYNAPSES);
  localparam int RW = clog2(NUM_REQ);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SYNAPSES - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(NUM_SYNAPSES);
  localparam logic [RW-1:0] LAST_REQ = RW'(NUM_REQ - 1);

  state_e             state;
  logic [AW-1:0]      idx;
  logic [WIDTH_P-1:0] bank [NUM_SYNAPSES];
  logic [RW-1:0]      ptr;
  logic [RW-1:0]      gnt_idx;
  logic [AW-1:0]      gnt_addr;
  logic [NUM_REQ-1:0] gnt;
  logic               rvalid;
  logic               done;
  logic [WIDTH_P-1:0] rdata;
  logic [RW-1:0]      rid;

  // A start pulse in SERVE suppresses that cycle's grant.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (bus.req_i),
    .en  (state == SERVE && !bus.start_i),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx  = RW'(i);
        gnt_addr = bus.addr_i[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      idx    <= '0;
      ptr    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
      done   <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(NUM_SYNAPSES); i++) bank[i] <= '0;
    end else begin
      done   <= 1'b0;
      rvalid <= |gnt;
      if (|gnt) begin
        rid   <= gnt_idx;
        ptr   <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
        // Indices past the populated bank read as zero.
        rdata <= ({1'b0, gnt_addr} < DEPTH) ? bank[gnt_addr] : '0;
      end
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          bank[idx] <= bus.rand_i;
          if (idx == LAST_IDX) begin
            state <= SERVE;
            done  <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SERVE: begin
          if (bus.start_i) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;
  assign bus.rid_o    = rid;
  assign bus.done_o   = done;
  assign bus.busy_o   = (state == LOAD);
  assign bus.ready_o  = (state == SERVE);

endmodule

// File: tb/tb_weight_sched.sv
// Bench for weight_sched: a 16-entry and a 12-entry instance share one stimulus stream.
module tb_weight_sched;

  localparam int NR = 2;
  localparam int W  = 8;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic              start;
  logic [W-1:0]      rnd;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  addr;

  weight_sched_if #(.NUM_SYNAPSES(16), .WIDTH_P(W), .NUM_REQ(NR)) bus0 ();
  weight_sched_if #(.NUM_SYNAPSES(12), .WIDTH_P(W), .NUM_REQ(NR)) bus1 ();

  assign bus0.start_i = start;
  assign bus0.rand_i  = rnd;
  assign bus0.req_i   = req;
  assign bus0.addr_i  = addr;
  assign bus1.start_i = start;
  assign bus1.rand_i  = rnd;
  assign bus1.req_i   = req;
  assign bus1.addr_i  = addr;

  weight_sched #(.NUM_SYNAPSES(16), .WIDTH_P(W), .NUM_REQ(NR)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  weight_sched #(.NUM_SYNAPSES(12), .WIDTH_P(W), .NUM_REQ(NR)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  logic [NR-1:0] o_gnt [2];
  logic          o_rvalid [2], o_busy [2], o_ready [2], o_done [2];
  logic [W-1:0]  o_rdata [2];
  logic          o_rid [2];
  assign o_gnt[0] = bus0.gnt_o;       assign o_gnt[1] = bus1.gnt_o;
  assign o_rvalid[0] = bus0.rvalid_o; assign o_rvalid[1] = bus1.rvalid_o;
  assign o_busy[0] = bus0.busy_o;     assign o_busy[1] = bus1.busy_o;
  assign o_ready[0] = bus0.ready_o;   assign o_ready[1] = bus1.ready_o;
  assign o_done[0] = bus0.done_o;     assign o_done[1] = bus1.done_o;
  assign o_rdata[0] = bus0.rdata_o;   assign o_rdata[1] = bus1.rdata_o;
  assign o_rid[0] = bus0.rid_o;       assign o_rid[1] = bus1.rid_o;

  // Reference model: what each instance must show, derived from the load/serve rules.
  int           ns [2] = '{16, 12};
  bit           m_loading [2], m_serving [2], m_rvalid [2], m_done [2];
  int           m_cnt [2], m_ptr [2], m_rid [2];
  logic [W-1:0] m_rdata [2];
  logic [W-1:0] m_bank [2][16];
  int           exp_g [2] = '{-1, -1};

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_loading[k] = 0; m_serving[k] = 0; m_rvalid[k] = 0; m_done[k] = 0;
    m_cnt[k] = 0; m_ptr[k] = 0; m_rid[k] = 0; m_rdata[k] = '0;
    for (int i = 0; i < 16; i++) m_bank[k][i] = '0;
  endtask

  function automatic int pick(input int k);
    int r;
    if (!m_serving[k] || start) return -1;
    for (int i = 0; i < NR; i++) begin
      r = (m_ptr[k] + i) % NR;
      if (req[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_step(input int k);
    int g, a;
    g = exp_g[k];
    m_done[k]   = 0;
    m_rvalid[k] = (g >= 0);
    if (g >= 0) begin
      a = int'(addr[g*AW +: AW]);
      m_rdata[k] = (a < ns[k]) ? m_bank[k][a] : '0;
      m_rid[k]   = g;
      m_ptr[k]   = (g + 1) % NR;
    end
    if (m_loading[k]) begin
      m_bank[k][m_cnt[k]] = rnd;
      m_cnt[k]++;
      if (m_cnt[k] == ns[k]) begin
        m_loading[k] = 0; m_serving[k] = 1; m_done[k] = 1;
      end
    end else if (start) begin
      m_loading[k] = 1; m_serving[k] = 0; m_cnt[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      exp_g[k] = pick(k);
      chk("gnt",    k, 32'(o_gnt[k]),    (exp_g[k] < 0) ? 32'd0 : (32'd1 << exp_g[k]));
      chk("busy",   k, 32'(o_busy[k]),   32'(m_loading[k]));
      chk("ready",  k, 32'(o_ready[k]),  32'(m_serving[k]));
      chk("done",   k, 32'(o_done[k]),   32'(m_done[k]));
      chk("rvalid", k, 32'(o_rvalid[k]), 32'(m_rvalid[k]));
      chk("rdata",  k, 32'(o_rdata[k]),  32'(m_rdata[k]));
      chk("rid",    k, 32'(o_rid[k]),    32'(m_rid[k]));
      if (rst_n) model_step(k);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt0, busy_cnt1;

  initial begin
    start = 1'b0; rnd = '0; req = '0; addr = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdata", 0, 32'(bus0.rdata_o), 32'h0);
    chk("rst_ready", 0, 32'(bus0.ready_o), 32'h0);
    cyc();

    // Load 0x10+i, with both requesters already asking during LOAD.
    start = 1'b1; cyc(); start = 1'b0;
    req = 2'b11; addr = {4'd7, 4'd3};
    busy_cnt0 = 0; busy_cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      rnd = W'(8'h10 + i);
      @(negedge clk);
      if (bus0.busy_o) busy_cnt0++;
      if (bus1.busy_o) busy_cnt1++;
      chk("early_gnt", 0, 32'(bus0.gnt_o), 32'h0);
      cyc();
    end
    chk("busy_len", 0, 32'(busy_cnt0), 32'd16);
    chk("busy_len", 1, 32'(busy_cnt1), 32'd12);

    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) chk("done_pulse", 0, 32'(bus0.done_o), 32'h1);
      if (j < 4)  chk("rr_gnt", 0, 32'(bus0.gnt_o), (j % 2 == 0) ? 32'h1 : 32'h2);
      if (j > 0) begin
        chk("rr_rvalid", 0, 32'(bus0.rvalid_o), 32'h1);
        chk("rr_rid",    0, 32'(bus0.rid_o), 32'((j - 1) % 2));
        chk("rr_rdata",  0, 32'(bus0.rdata_o), ((j - 1) % 2 == 0) ? 32'h13 : 32'h17);
      end
      cyc();
    end

    req = 2'b01; addr = {4'd0, 4'd5};
    @(negedge clk);
    chk("rd5_gnt", 0, 32'(bus0.gnt_o), 32'h1);
    cyc();
    addr = {4'd0, 4'd15};
    @(negedge clk);
    chk("rd5_data", 0, 32'(bus0.rdata_o), 32'h15);
    chk("rd5_data", 1, 32'(bus1.rdata_o), 32'h15);
    cyc();
    @(negedge clk);
    chk("oor_rvalid", 1, 32'(bus1.rvalid_o), 32'h1);
    chk("oor_rdata",  1, 32'(bus1.rdata_o), 32'h0);
    chk("rd15_data",  0, 32'(bus0.rdata_o), 32'h1f);
    cyc();

    // Reload from SERVE with requests held.
    req = 2'b11; addr = {4'd7, 4'd3};
    cyc();
    start = 1'b1;
    @(negedge clk);
    chk("reload_gnt",    0, 32'(bus0.gnt_o), 32'h0);
    chk("reload_rvalid", 0, 32'(bus0.rvalid_o), 32'h1);
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("reload_busy", 0, 32'(bus0.busy_o), 32'h1);
    for (int i = 0; i < 24; i++) begin
      rnd = W'($urandom);
      cyc();
    end

    // Reset at load index 7, then a zero load.
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rnd = W'($urandom);
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   0, 32'(bus0.busy_o), 32'h0);
    chk("mid_rst_rvalid", 0, 32'(bus0.rvalid_o), 32'h0);
    chk("mid_rst_rdata",  0, 32'(bus0.rdata_o), 32'h0);
    chk("mid_rst_gnt",    0, 32'(bus0.gnt_o), 32'h0);
    cyc();
    rst_n = 1'b1; req = 2'b01; addr = {4'd0, 4'd5};
    cyc(); cyc();
    @(negedge clk);
    chk("no_autostart", 0, 32'(bus0.ready_o), 32'h0);
    cyc();
    start = 1'b1; rnd = '0; cyc(); start = 1'b0;
    repeat (16) cyc();
    @(negedge clk);
    chk("zero_gnt", 0, 32'(bus0.gnt_o), 32'h1);
    cyc();
    @(negedge clk);
    chk("zero_rvalid", 0, 32'(bus0.rvalid_o), 32'h1);
    chk("zero_rdata",  0, 32'(bus0.rdata_o), 32'h0);
    cyc();

    // Random traffic; requesters hold until granted, then redraw.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      rnd   = W'($urandom);
      for (int r = 0; r < NR; r++) begin
        if (!req[r] || exp_g[0] == r) begin
          req[r] = ($urandom_range(0, 2) != 0);
          addr[r*AW +: AW] = AW'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
